i2s_mix_sched: RTL and testbench
================================

Name: i2s_mix_sched

Overview:
Frame scheduler and mixer that feeds left_chan/right_chan of the I2S transmitter.
- Watches the transmitter's lrclk and opens one collection window per audio frame.
- Polls NUM_VOICES synth voices in sequence over a req/ack handshake and sums their stereo samples.
- Saturates the sums and presents them as stable, frame-aligned words for the transmitter to load.
- Fixed one-frame latency; output words never change mid-frame.

Parameters:
DATA_WIDTH, 16, sample width of voice inputs and channel outputs (two's complement).
NUM_VOICES, 4, number of voices polled per frame (1..16).
VIDX_W, 2, width of voice_idx; must satisfy 2^VIDX_W >= NUM_VOICES.
TIMEOUT, 255, cycles to wait for voice_ack before the voice is skipped.

Ports:
clk  in  1  system clock (50 MHz), same domain as the transmitter.
rst  in  1  synchronous, active-high reset.
lrclk  in  1  word clock from the transmitter; already synchronous to clk.
mute  in  1  when high at commit, zeros are committed instead of the mix.
voice_req  out  1  sample request to the voice addressed by voice_idx.
voice_idx  out  VIDX_W  index of the voice being polled.
voice_ack  in  1  voice has valid data on voice_l/voice_r this cycle.
voice_l  in  DATA_WIDTH  signed left sample of the addressed voice.
voice_r  in  DATA_WIDTH  signed right sample of the addressed voice.
left_chan  out  DATA_WIDTH  committed left word, held for a whole frame.
right_chan  out  DATA_WIDTH  committed right word, held for a whole frame.
frame_strobe  out  1  one-cycle pulse in the cycle after a commit.
underrun  out  1  sticky; a frame start arrived before collection finished.
timeout_err  out  1  sticky; at least one voice failed to ack within TIMEOUT.

Behaviour:
- Frame start: lrclk_prev is a register; frame_start = lrclk_prev & ~lrclk (falling edge).
- Reset values:
  - left_chan=0, right_chan=0, voice_req=0, voice_idx=0, frame_strobe=0, underrun=0, timeout_err=0.
  - lrclk_prev=0, shadow_l/shadow_r=0, shadow_valid=1, state=IDLE, acc=0, wait counter=0.
- Accumulators: acc_l/acc_r are signed, DATA_WIDTH+VIDX_W+1 bits wide, and cannot overflow.
- States: IDLE, REQ, DONE.
- On frame_start, regardless of state:
  - If shadow_valid: left/right_chan <= mute ? 0 : shadow.
  - Otherwise: outputs hold their previous values and underrun <= 1.
  - frame_strobe asserts in the next cycle.
  - acc cleared, voice_idx <= 0, shadow_valid <= 0, state <= REQ. A collection in progress is aborted.
- REQ:
  - voice_req=1 and stays high until either ack or timeout.
  - Ack is any cycle with voice_req&voice_ack. On ack: acc += sign-extended voice_l/voice_r, wait counter cleared.
  - Timeout is the wait counter reaching TIMEOUT without ack. On timeout: the voice contributes 0, timeout_err <= 1, counter cleared.
  - After ack or timeout: if voice_idx==NUM_VOICES-1, go to DONE and drop voice_req the next cycle; otherwise voice_idx+1 and stay in REQ.
  - voice_req deasserts for exactly 0 cycles between voices; voice_idx changes in the same cycle as the accepted ack.
- DONE:
  - shadow <= saturate(acc) to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], shadow_valid <= 1, state <= IDLE.
- IDLE: voice_req=0; wait for frame_start.
- Simultaneous frame_start and final ack: frame_start wins. The partial mix is discarded and underrun <= 1.
- Sticky flags clear only on rst.
- rst mid-collection: voice_req drops in the next cycle and all state returns to reset values.
- Latency: samples collected in frame N appear on the outputs at the frame N+1 start.

Optional Feature:
MIX_SCHED_GAIN_EN
- Defined:
  - Adds input gain_shift [2:0].
  - At DONE, acc is arithmetic-right-shifted by gain_shift before saturation.
  - gain_shift is sampled in the DONE cycle.
- Undefined: the port is absent and there is no shift, i.e. shift = 0.

Test Plan:
- Reset then lrclk toggling; voices ack 1 cycle after req with l=0x0100·(idx+1), r=-0x0010 -> next frame left_chan=0x0A00, right_chan=0xFFC0; frame_strobe pulses once per lrclk fall.
- All 4 voices l=0x7000 -> left_chan saturates to 0x7FFF; all 4 voices l=0x9000 -> left_chan=0x8000.
- Voice 2 never acks -> voice_idx advances after 255 wait cycles; timeout_err=1; left/right = sum of voices 0, 1, 3.
- Voice 3 ack delayed past the next lrclk fall -> underrun=1; outputs keep the previous frame's values; the new collection starts at voice_idx=0.
- mute=1 at a frame start -> left_chan=right_chan=0 for that frame; the mix returns at the next frame start once mute=0.
- rst asserted while voice_req=1 -> next cycle voice_req=0, outputs=0, flags=0; with MIX_SCHED_GAIN_EN, gain_shift=2 and a sum of 0x0A00 -> 0x0280.

Source files
------------

// File: rtl/i2s_mix_sched_if.sv
// Voice polling bus between the mix scheduler (master) and the synth voices (slave).
interface i2s_mix_sched_if #(
    parameter int DATA_WIDTH = 16,
    parameter int VIDX_W     = 2
);
    logic                         voice_req;
    logic [VIDX_W-1:0]            voice_idx;
    logic                         voice_ack;
    logic signed [DATA_WIDTH-1:0] voice_l;
    logic signed [DATA_WIDTH-1:0] voice_r;

    modport master (output voice_req, voice_idx, input voice_ack, voice_l, voice_r);
    modport slave  (input voice_req, voice_idx, output voice_ack, voice_l, voice_r);
endinterface

// File: rtl/i2s_mix_sched.sv
// Per-frame voice poller and saturating stereo mixer feeding the I2S transmitter.
// Optional gain stage (arithmetic right shift before saturation) under MIX_SCHED_GAIN_EN.
module i2s_mix_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_lrclk,
    input  logic                  i_mute,
`ifdef MIX_SCHED_GAIN_EN
    input  logic [2:0]            i_gain_shift,
`endif
    i2s_mix_sched_if.master       vif,
    output logic [DATA_WIDTH-1:0] o_left_chan,
    output logic [DATA_WIDTH-1:0] o_right_chan,
    output logic                  o_frame_strobe,
    output logic                  o_underrun,
    output logic                  o_timeout_err
);
    localparam int ACC_W  = DATA_WIDTH + VIDX_W + 1;
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t                  r_state;
    logic                    r_lrclk_prev;
    logic                    r_req;
    logic [VIDX_W-1:0]       r_idx;
    logic [WAIT_W-1:0]       r_wait;
    logic signed [ACC_W-1:0] r_acc_l, r_acc_r;
    logic [DATA_WIDTH-1:0]   r_shadow_l, r_shadow_r;
    logic                    r_shadow_valid;
    logic [DATA_WIDTH-1:0]   r_left, r_right;
    logic                    r_strobe, r_underrun, r_timeout_err;

    logic                    w_frame_start, w_ack, w_timeout, w_last;
    logic [2:0]              w_shift;
    logic signed [ACC_W-1:0] w_ext_l, w_ext_r, w_sh_l, w_sh_r;

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
        else if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
        else                  return v[DATA_WIDTH-1:0];
    endfunction

`ifdef MIX_SCHED_GAIN_EN
    assign w_shift = i_gain_shift;
`else
    assign w_shift = 3'd0;
`endif

    assign w_frame_start = r_lrclk_prev & ~i_lrclk;
    assign w_ack         = r_req & vif.voice_ack;
    // An ack landing on the timeout cycle still counts as a real sample.
    assign w_timeout     = r_req & ~vif.voice_ack & (r_wait == WAIT_W'(TIMEOUT));
    assign w_last        = (r_idx == VIDX_W'(NUM_VOICES - 1));
    assign w_ext_l       = {{(ACC_W-DATA_WIDTH){vif.voice_l[DATA_WIDTH-1]}}, vif.voice_l};
    assign w_ext_r       = {{(ACC_W-DATA_WIDTH){vif.voice_r[DATA_WIDTH-1]}}, vif.voice_r};
    assign w_sh_l        = r_acc_l >>> w_shift;
    assign w_sh_r        = r_acc_r >>> w_shift;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_lrclk_prev   <= 1'b0;
            r_req          <= 1'b0;
            r_idx          <= '0;
            r_wait         <= '0;
            r_acc_l        <= '0;
            r_acc_r        <= '0;
            r_shadow_l     <= '0;
            r_shadow_r     <= '0;
            r_shadow_valid <= 1'b1;
            r_left         <= '0;
            r_right        <= '0;
            r_strobe       <= 1'b0;
            r_underrun     <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_lrclk_prev <= i_lrclk;
            r_strobe     <= w_frame_start;
            // Frame start overrides everything, aborting any unfinished collection.
            if (w_frame_start) begin
                if (r_shadow_valid) begin
                    r_left  <= i_mute ? '0 : r_shadow_l;
                    r_right <= i_mute ? '0 : r_shadow_r;
                end else begin
                    r_underrun <= 1'b1;
                end
                r_acc_l        <= '0;
                r_acc_r        <= '0;
                r_idx          <= '0;
                r_wait         <= '0;
                r_shadow_valid <= 1'b0;
                r_req          <= 1'b1;
                r_state        <= S_REQ;
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (w_ack || w_timeout) begin
                            if (w_ack) begin
                                r_acc_l <= r_acc_l + w_ext_l;
                                r_acc_r <= r_acc_r + w_ext_r;
                            end else begin
                                r_timeout_err <= 1'b1;
                            end
                            r_wait <= '0;
                            if (w_last) begin
                                r_req   <= 1'b0;
                                r_state <= S_DONE;
                            end else begin
                                r_idx <= r_idx + VIDX_W'(1);
                            end
                        end else begin
                            r_wait <= r_wait + WAIT_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_shadow_l     <= sat(w_sh_l);
                        r_shadow_r     <= sat(w_sh_r);
                        r_shadow_valid <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                    default: r_req <= 1'b0;
                endcase
            end
        end
    end

    assign vif.voice_req  = r_req;
    assign vif.voice_idx  = r_idx;
    assign o_left_chan    = r_left;
    assign o_right_chan   = r_right;
    assign o_frame_strobe = r_strobe;
    assign o_underrun     = r_underrun;
    assign o_timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_i2s_mix_sched.sv
// Directed bench for i2s_mix_sched: per-frame mix model plus literal spot checks.
module tb_i2s_mix_sched;
    localparam int DW = 16;
    localparam int NV = 4;
    localparam int VW = 2;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lrclk = 1'b1;
    logic mute = 1'b0;
`ifdef MIX_SCHED_GAIN_EN
    logic [2:0] gain_shift = 3'd0;
`endif
    logic [DW-1:0] left_chan, right_chan;
    logic frame_strobe, underrun, timeout_err;

    i2s_mix_sched_if #(.DATA_WIDTH(DW), .VIDX_W(VW)) vif();

    i2s_mix_sched #(.DATA_WIDTH(DW), .NUM_VOICES(NV), .VIDX_W(VW), .TIMEOUT(TO)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_lrclk        (lrclk),
        .i_mute         (mute),
`ifdef MIX_SCHED_GAIN_EN
        .i_gain_shift   (gain_shift),
`endif
        .vif            (vif),
        .o_left_chan    (left_chan),
        .o_right_chan   (right_chan),
        .o_frame_strobe (frame_strobe),
        .o_underrun     (underrun),
        .o_timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit cmp_en = 1'b0;

    task automatic chk_cond(input string name, input bit ok, input int act, input int exp);
        nvec++;
        if (!ok) begin
            nerr++;
            if (nerr <= 30) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        chk_cond(name, act == exp, act, exp);
    endtask

    // Voice responders: ack vdly cycles after the request appears; vdly < 0 never acks.
    int vl[NV], vr[NV], vdly[NV];
    int v_cnt = 0;
    bit v_last_req = 1'b0;
    logic [VW-1:0] v_last_idx = '0;
    always @(negedge clk) begin
        if (vif.voice_req === 1'b1 && v_last_req && vif.voice_idx == v_last_idx) v_cnt = v_cnt + 1;
        else v_cnt = 0;
        v_last_req = (vif.voice_req === 1'b1);
        v_last_idx = vif.voice_idx;
        vif.voice_ack = (vif.voice_req === 1'b1) && (vdly[vif.voice_idx] >= 0) &&
                        (v_cnt >= vdly[vif.voice_idx]);
        vif.voice_l = DW'(vl[vif.voice_idx]);
        vif.voice_r = DW'(vr[vif.voice_idx]);
    end

    // Frame-level model: a collection's result is committed at the following frame start.
    logic [DW-1:0] m_l, m_r, m_sh_l, m_sh_r, nxt_l, nxt_r;
    logic m_strobe, m_und, m_terr, m_valid, m_pterr, m_prev, nxt_ok, nxt_terr;

    function automatic logic [DW-1:0] sat16(input int v);
        int t;
        t = v;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        return t[DW-1:0];
    endfunction

    task automatic setup(input bit ok);
        int sl = 0;
        int sr = 0;
        nxt_terr = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (vdly[i] >= 0) begin
                sl += vl[i];
                sr += vr[i];
            end else begin
                nxt_terr = 1'b1;
            end
        end
`ifdef MIX_SCHED_GAIN_EN
        sl = sl >>> gain_shift;
        sr = sr >>> gain_shift;
`endif
        nxt_l  = sat16(sl);
        nxt_r  = sat16(sr);
        nxt_ok = ok;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_l <= '0; m_r <= '0; m_sh_l <= '0; m_sh_r <= '0;
            m_strobe <= 1'b0; m_und <= 1'b0; m_terr <= 1'b0;
            m_valid <= 1'b1; m_pterr <= 1'b0; m_prev <= 1'b0;
        end else begin
            m_prev   <= lrclk;
            m_strobe <= m_prev && !lrclk;
            if (m_prev && !lrclk) begin
                if (m_valid) begin
                    m_l <= mute ? '0 : m_sh_l;
                    m_r <= mute ? '0 : m_sh_r;
                end else begin
                    m_und <= 1'b1;
                end
                m_terr  <= m_terr | m_pterr;
                m_sh_l  <= nxt_l;
                m_sh_r  <= nxt_r;
                m_valid <= nxt_ok;
                m_pterr <= nxt_terr;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("left_chan", int'(left_chan), int'(m_l));
            chk("right_chan", int'(right_chan), int'(m_r));
            chk("frame_strobe", int'(frame_strobe), int'(m_strobe));
            chk("underrun", int'(underrun), int'(m_und));
            if (m_strobe) chk("timeout_err", int'(timeout_err), int'(m_terr));
        end
    end

    task automatic cfg_a();
        for (int i = 0; i < NV; i++) begin
            vl[i] = 256 * (i + 1);
            vr[i] = -16;
            vdly[i] = 1;
        end
    endtask

    // One frame starting with the lrclk fall; ok says whether the collection completes.
    task automatic frame(input int half, input bit ok);
        setup(ok);
        lrclk = 1'b0;
        repeat (half) @(negedge clk);
        lrclk = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        cfg_a();
        setup(1'b1);
        repeat (3) @(negedge clk);
        chk("rst_left", int'(left_chan), 0);
        chk("rst_right", int'(right_chan), 0);
        chk("rst_req", int'(vif.voice_req), 0);
        chk("rst_idx", int'(vif.voice_idx), 0);
        chk("rst_strobe", int'(frame_strobe), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_terr", int'(timeout_err), 0);
        cmp_en = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic mix: 0x100+0x200+0x300+0x400 and 4 x -0x10
        frame(32, 1'b1);
        frame(32, 1'b1);
        chk("mix_left", int'(left_chan), 'h0A00);
        chk("mix_right", int'(right_chan), 'hFFC0);
        frame(32, 1'b1);

        // Saturation both ways
        for (int i = 0; i < NV; i++) vl[i] = 'h7000;
        frame(32, 1'b1);
        frame(32, 1'b1);
        chk("sat_pos", int'(left_chan), 'h7FFF);
        for (int i = 0; i < NV; i++) vl[i] = -'h7000;
        frame(32, 1'b1);
        frame(32, 1'b1);
        chk("sat_neg", int'(left_chan), 'h8000);

        // Voice 2 silent: skipped after the wait budget
        cfg_a();
        vdly[2] = -1;
        fork
            frame(200, 1'b1);
            begin
                int n;
                bit still;
                n = 0;
                got = 1'b0;
                for (int k = 0; k < 400 && !got; k++) begin
                    @(negedge clk);
                    got = (vif.voice_req === 1'b1) && (vif.voice_idx == 2);
                end
                if (got) begin
                    n = 1;
                    still = 1'b1;
                    for (int k = 0; k < 600 && still; k++) begin
                        @(negedge clk);
                        if ((vif.voice_req === 1'b1) && (vif.voice_idx == 2)) n++;
                        else still = 1'b0;
                    end
                end
                chk_cond("timeout_wait", (n >= TO) && (n <= TO + 1), n, TO);
            end
        join
        cfg_a();
        frame(32, 1'b1);
        chk("timeout_left", int'(left_chan), 'h0700);
        chk("timeout_right", int'(right_chan), 'hFFD0);
        chk("timeout_flag", int'(timeout_err), 1);

        // Underrun: voice 3 too slow, previous words held
        for (int i = 0; i < NV; i++) vl[i] = 16 * (i + 1);
        frame(32, 1'b1);
        vdly[3] = 1000;
        frame(32, 1'b0);
        chk("pre_underrun_left", int'(left_chan), 'h00A0);
        cfg_a();
        frame(32, 1'b1);
        chk("underrun_hold", int'(left_chan), 'h00A0);
        chk("underrun_flag", int'(underrun), 1);
        frame(32, 1'b1);
        chk("post_underrun_left", int'(left_chan), 'h0A00);

        // Mute for one frame
        mute = 1'b1;
        frame(32, 1'b1);
        chk("mute_left", int'(left_chan), 0);
        chk("mute_right", int'(right_chan), 0);
        mute = 1'b0;
        frame(32, 1'b1);
        chk("unmute_left", int'(left_chan), 'h0A00);

`ifdef MIX_SCHED_GAIN_EN
        gain_shift = 3'd2;
        frame(32, 1'b1);
        frame(32, 1'b1);
        chk("gain_left", int'(left_chan), 'h0280);
        chk("gain_right", int'(right_chan), 'hFFF0);
        gain_shift = 3'd0;
`endif

        // Reset while a voice is being polled
        setup(1'b1);
        lrclk = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = (vif.voice_req === 1'b1);
        end
        chk("req_before_rst", int'(got), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", int'(vif.voice_req), 0);
        chk("midrst_left", int'(left_chan), 0);
        chk("midrst_right", int'(right_chan), 0);
        chk("midrst_underrun", int'(underrun), 0);
        chk("midrst_terr", int'(timeout_err), 0);
        rst = 1'b0;
        lrclk = 1'b1;
        repeat (4) @(negedge clk);
        frame(32, 1'b1);
        chk("after_rst_left", int'(left_chan), 0);
        frame(32, 1'b1);
        chk("after_rst_mix", int'(left_chan), 'h0A00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
